// File: rtl/vga_sync_ctrl_pkg.sv
// Shared VGA timing definitions: axis phase encoding and the default
// 640x480@60 timing constants used by every VGA block in this codebase.
package vga_sync_ctrl_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // 640x480@60 with a 25 MHz pixel clock
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    // Phase order along one axis; BACK returns to ACTIVE
    function automatic phase_t phase_after(input phase_t ph);
        case (ph)
            PH_ACTIVE: phase_after = PH_FRONT;
            PH_FRONT:  phase_after = PH_SYNC;
            PH_SYNC:   phase_after = PH_BACK;
            default:   phase_after = PH_ACTIVE;
        endcase
    endfunction

endpackage

// File: rtl/enableN_gen.sv
// Divide-by-ULIMIT enable generator. o_en is a registered one-clk pulse every
// ULIMIT cycles, starting the first cycle after reset release. o_en_pre is
// the combinational value that o_en takes at the next edge, so downstream
// registers can update on the same edge that raises o_en.
module enableN_gen #(
    parameter int ULIMIT = 2
) (
    input  logic clk,
    input  logic i_sclr,
    output logic o_en,
    output logic o_en_pre
);

    localparam int CW = (ULIMIT > 1) ? $clog2(ULIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(ULIMIT - 1);

    logic [CW-1:0] cnt_reg;
    logic          en_reg;

    assign o_en_pre = ~i_sclr & (cnt_reg == '0);
    assign o_en     = en_reg;

    // Free-running divider; phase zero is the first cycle after reset
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            cnt_reg <= '0;
            en_reg  <= 1'b0;
        end else begin
            en_reg  <= o_en_pre;
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/vga_axis_ctrl.sv
// One timing axis (horizontal or vertical): a position counter plus the
// ACTIVE->FRONT->SYNC->BACK phase FSM. Exposes next-phase so the parent can
// register decoded outputs on the same edge the counter moves.
module vga_axis_ctrl
    import vga_sync_ctrl_pkg::*;
#(
    parameter int VISIBLE = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter int W       = 10
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         i_step,
    output logic [W-1:0] o_cnt,
    output logic [1:0]   o_phase,
    output logic [1:0]   o_phase_next,
    output logic         o_wrap
);

    localparam logic [W-1:0] LAST_ACT   = W'(VISIBLE - 1);
    localparam logic [W-1:0] LAST_FRONT = W'(VISIBLE + FRONT - 1);
    localparam logic [W-1:0] LAST_SYNC  = W'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [W-1:0] LAST_BACK  = W'(VISIBLE + FRONT + SYNC + BACK - 1);

    logic [W-1:0] cnt_reg, cnt_next, phase_last;
    phase_t       phase_reg, phase_next;
    logic         wrap;

    assign o_cnt        = cnt_reg;
    assign o_phase      = phase_reg;
    assign o_phase_next = phase_next;
    assign o_wrap       = wrap;

    // Next counter/phase: advance on step, leave a phase at its last position
    always_comb begin
        case (phase_reg)
            PH_ACTIVE: phase_last = LAST_ACT;
            PH_FRONT:  phase_last = LAST_FRONT;
            PH_SYNC:   phase_last = LAST_SYNC;
            default:   phase_last = LAST_BACK;
        endcase
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        wrap       = 1'b0;
        if (i_step) begin
            if (cnt_reg == LAST_BACK) begin
                cnt_next = '0;
                wrap     = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
            if (cnt_reg == phase_last) begin
                phase_next = phase_after(phase_reg);
            end
        end
    end

    // Counter and phase state
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg   <= '0;
            phase_reg <= PH_ACTIVE;
        end else begin
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
        end
    end

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA sync generator: pixel enable divider, H and V axis FSMs, and registered
// sync/DE/frame-start outputs aligned with the counters they decode.
module vga_sync_ctrl
    import vga_sync_ctrl_pkg::*;
#(
    parameter int   PIX_DIV   = 2,
    parameter int   H_VISIBLE = VGA_H_VISIBLE,
    parameter int   H_FRONT   = VGA_H_FRONT,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BACK    = VGA_H_BACK,
    parameter int   V_VISIBLE = VGA_V_VISIBLE,
    parameter int   V_FRONT   = VGA_V_FRONT,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BACK    = VGA_V_BACK,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   HW        = 10,
    parameter int   VW        = 10
) (
    input  logic          clk,
    input  logic          i_sclr,
    output logic          o_pix_en,
    output logic [HW-1:0] o_hcnt,
    output logic [VW-1:0] o_vcnt,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic          o_frame_start
);

    localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (HT > (1 << HW)) begin : g_hw_too_small
        $error("vga_sync_ctrl: HW too narrow for horizontal total");
    end
    if (VT > (1 << VW)) begin : g_vw_too_small
        $error("vga_sync_ctrl: VW too narrow for vertical total");
    end

    logic       pix_tick;
    logic       started_reg;
    logic       h_step, h_wrap, v_wrap;
    logic [1:0] h_phase, h_phase_next, v_phase, v_phase_next;
    logic       hsync_reg, vsync_reg, de_reg, fs_reg;

    enableN_gen #(
        .ULIMIT (PIX_DIV)
    ) u_pix_en (
        .clk      (clk),
        .i_sclr   (i_sclr),
        .o_en     (o_pix_en),
        .o_en_pre (pix_tick)
    );

    // The first tick after reset presents pixel (0,0) without advancing
    assign h_step = pix_tick & started_reg;

    vga_axis_ctrl #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .W       (HW)
    ) u_h_axis (
        .clk          (clk),
        .srst         (i_sclr),
        .i_step       (h_step),
        .o_cnt        (o_hcnt),
        .o_phase      (h_phase),
        .o_phase_next (h_phase_next),
        .o_wrap       (h_wrap)
    );

    vga_axis_ctrl #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .W       (VW)
    ) u_v_axis (
        .clk          (clk),
        .srst         (i_sclr),
        .i_step       (h_wrap),
        .o_cnt        (o_vcnt),
        .o_phase      (v_phase),
        .o_phase_next (v_phase_next),
        .o_wrap       (v_wrap)
    );

    assign o_hsync       = hsync_reg;
    assign o_vsync       = vsync_reg;
    assign o_de          = de_reg;
    assign o_frame_start = fs_reg;

    // Decode next axis state so outputs land with the counter values they describe
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            started_reg <= 1'b0;
            hsync_reg   <= ~SYNC_POL;
            vsync_reg   <= ~SYNC_POL;
            de_reg      <= 1'b0;
            fs_reg      <= 1'b0;
        end else begin
            fs_reg <= pix_tick & (~started_reg | v_wrap);
            if (pix_tick) begin
                started_reg <= 1'b1;
                hsync_reg   <= (h_phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                vsync_reg   <= (v_phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                de_reg      <= (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
            end
        end
    end

    // Current phases are only consumed through their next-state values
    logic unused_phase;
    assign unused_phase = ^{h_phase, v_phase};

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl with a small timing (H 4/1/2/1, V 3/1/1/1) at
// PIX_DIV=2 and PIX_DIV=1. Expected outputs come from the elapsed clock count
// since reset release, using plain division and modulo.
module tb_vga_sync_ctrl;

    localparam int HV = 4, HF = 1, HS = 2, HB = 1;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic clk = 1'b0;
    logic sclr = 1'b1;
    always #5 clk = ~clk;

    logic       a_pe, a_hs, a_vs, a_de, a_fs;
    logic [3:0] a_h;
    logic [2:0] a_v;
    logic       b_pe, b_hs, b_vs, b_de, b_fs;
    logic [3:0] b_h;
    logic [2:0] b_v;

    vga_sync_ctrl #(
        .PIX_DIV (2), .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .SYNC_POL (1'b0), .HW (4), .VW (3)
    ) dut_a (
        .clk (clk), .i_sclr (sclr), .o_pix_en (a_pe), .o_hcnt (a_h), .o_vcnt (a_v),
        .o_hsync (a_hs), .o_vsync (a_vs), .o_de (a_de), .o_frame_start (a_fs)
    );

    vga_sync_ctrl #(
        .PIX_DIV (1), .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .SYNC_POL (1'b0), .HW (4), .VW (3)
    ) dut_b (
        .clk (clk), .i_sclr (sclr), .o_pix_en (b_pe), .o_hcnt (b_h), .o_vcnt (b_v),
        .o_hsync (b_hs), .o_vsync (b_vs), .o_de (b_de), .o_frame_start (b_fs)
    );

    // Clocks elapsed since the first edge with reset low; -1 while in reset
    int t = -1;
    always @(posedge clk) t <= sclr ? -1 : t + 1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_a = -1;
    int last_b = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
            $error("check %s", tag);
        end
    endtask

    // Reference: pixel index = t/div, column/line by modulo on the totals
    task automatic check_dut(input string nm, input int div,
                             input logic pe, input logic [31:0] h, input logic [31:0] v,
                             input logic hs, input logic vs, input logic de, input logic fs);
        int ep, eh, ev, ehs, evs, ede, efs, p;
        if (t < 0) begin
            ep = 0; eh = 0; ev = 0; ehs = 1; evs = 1; ede = 0; efs = 0;
        end else begin
            p   = t / div;
            ep  = (t % div == 0) ? 1 : 0;
            eh  = p % HT;
            ev  = (p / HT) % VT;
            ehs = (eh >= HV + HF && eh < HV + HF + HS) ? 0 : 1;
            evs = (ev >= VV + VF && ev < VV + VF + VS) ? 0 : 1;
            ede = (eh < HV && ev < VV) ? 1 : 0;
            efs = (ep == 1 && eh == 0 && ev == 0) ? 1 : 0;
        end
        chk({nm, "_pix_en"}, 32'(pe), ep);
        chk({nm, "_hcnt"}, h, eh);
        chk({nm, "_vcnt"}, v, ev);
        chk({nm, "_hsync"}, 32'(hs), ehs);
        chk({nm, "_vsync"}, 32'(vs), evs);
        chk({nm, "_de"}, 32'(de), ede);
        chk({nm, "_frame_start"}, 32'(fs), efs);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_dut("a", 2, a_pe, 32'(a_h), 32'(a_v), a_hs, a_vs, a_de, a_fs);
        check_dut("b", 1, b_pe, 32'(b_h), 32'(b_v), b_hs, b_vs, b_de, b_fs);
        if (t < 0) begin
            last_a = -1;
            last_b = -1;
        end else begin
            if (a_fs === 1'b1) begin
                if (last_a >= 0) chk("a_frame_period", 32'(cyc - last_a), 2 * HT * VT);
                last_a = cyc;
            end
            if (b_fs === 1'b1) begin
                if (last_b >= 0) chk("b_frame_period", 32'(cyc - last_b), HT * VT);
                last_b = cyc;
            end
        end
    endtask

    initial begin
        int found;
        int n, r;

        // Reset hold, then two full frames of the slow instance
        sclr = 1'b1;
        @(posedge clk);
        step();
        step();
        sclr = 1'b0;
        $display("release after reset: running %0d cycles", 2 * 2 * HT * VT + 8);
        repeat (2 * 2 * HT * VT + 8) step();

        // Mid-frame reset at line 2, column 5 of the PIX_DIV=2 instance
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            step();
            if (t >= 0 && ((t / 2) % HT) == 5 && (((t / 2) / HT) % VT) == 2) found = 1;
        end
        chk("seek_v2_h5", 32'(found), 1);
        $display("mid-frame reset at vcnt=2 hcnt=5");
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        repeat (40) step();

        // Random run lengths interleaved with random-length resets
        for (int seg = 0; seg < 20; seg++) begin
            n = $urandom_range(1, 300);
            r = $urandom_range(1, 3);
            $display("segment %0d: run %0d cycles, reset %0d cycles", seg, n, r);
            repeat (n) step();
            sclr = 1'b1;
            repeat (r) step();
            sclr = 1'b0;
        end
        repeat (120) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_ctrl.md
VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 The block SHALL have parameter PIX_DIV, default 2, system clocks per pixel (>=1).
REQ-002 The block SHALL have parameters H_VISIBLE/H_FRONT/H_SYNC/H_BACK, defaults 640/16/96/48, horizontal phase lengths in pixels.
REQ-003 The block SHALL have parameters V_VISIBLE/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33, vertical phase lengths in lines.
REQ-004 The block SHALL have parameter SYNC_POL, default 0, active level of o_hsync and o_vsync.
REQ-005 The block SHALL have parameters HW and VW, default 10 each, widths of o_hcnt and o_vcnt.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port i_sclr, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port o_pix_en, output, 1 bit: pixel-rate enable, one clk wide.
REQ-009 The block SHALL have ports o_hcnt and o_vcnt, outputs, HW and VW bits: current pixel column and line.
REQ-010 The block SHALL have ports o_hsync and o_vsync, outputs, 1 bit each: sync pulses at SYNC_POL level.
REQ-011 The block SHALL have port o_de, output, 1 bit: display enable, high in the visible region.
REQ-012 The block SHALL have port o_frame_start, output, 1 bit: one-clk pulse at the first pixel of each frame.

Function
REQ-013 The block SHALL assert o_pix_en in the first clk cycle after i_sclr deasserts, and then once every PIX_DIV cycles; for PIX_DIV=1 it SHALL be constant high.
REQ-014 The block SHALL change o_hcnt, o_vcnt and the phase state only in cycles where o_pix_en=1; in all other cycles every output except o_pix_en SHALL hold.
REQ-015 o_hcnt SHALL count 0..HT-1, with HT=H_VISIBLE+H_FRONT+H_SYNC+H_BACK, and wrap to 0.
REQ-016 o_vcnt SHALL increment only in the pixel-enabled cycle where o_hcnt=HT-1; it SHALL count 0..VT-1 (VT = sum of V phases) and wrap to 0 together with o_hcnt.
REQ-017 Each axis SHALL use a 4-state FSM, ACTIVE->FRONT->SYNC->BACK->ACTIVE, changing state when its counter reaches the last value of the current phase.
REQ-018 o_hsync SHALL be at SYNC_POL iff the H state is SYNC (o_hcnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]); otherwise it SHALL be at ~SYNC_POL. o_vsync SHALL follow the same rule on the V axis.
REQ-019 o_de SHALL be 1 iff both the H and V states are ACTIVE.
REQ-020 o_hsync, o_vsync, o_de and o_frame_start SHALL be registered and aligned to the same cycle as the o_hcnt/o_vcnt values they decode, with zero relative latency.
REQ-021 o_frame_start SHALL be 1 exactly in the cycle where o_pix_en=1 and o_hcnt=0 and o_vcnt=0, including the first tick after reset.
REQ-022 Counter widths SHALL satisfy HT<=2^HW and VT<=2^VW; a violation SHALL be flagged by an elaboration-time check.

Reset
REQ-023 While i_sclr=1, the block SHALL hold o_hcnt=0, o_vcnt=0, both FSMs in ACTIVE, o_de=0, o_frame_start=0, o_pix_en=0, and o_hsync=o_vsync=~SYNC_POL.
REQ-024 An i_sclr asserted mid-frame SHALL take effect at the next clk edge, discarding the frame; counting SHALL restart per REQ-013/REQ-021.

Structure
REQ-025 The default 640x480@60 timing constants SHALL reside in the shared timing include file, so other VGA blocks use the same values.
REQ-026 The pixel enable SHALL be produced by one instance of the existing enableN_gen, with ULIMIT=PIX_DIV and i_sclr driven by the block's reset.
REQ-027 The H and V FSMs SHALL both be instances of one sub-module, vga_axis_ctrl, parameterised by phase lengths and width, with a step-enable input and a wrap output.

Verification (small timing: PIX_DIV=2, H 4/1/2/1 so HT=8, V 3/1/1/1 so VT=6, SYNC_POL=0)
REQ-028 Pulse i_sclr for 1 cycle -> first cycle after release: o_pix_en=1, o_frame_start=1, hcnt=0, vcnt=0, o_de=1; o_pix_en then alternates 0/1.
REQ-029 Run one line -> o_hcnt 0..7, each value held for 2 clks; o_hsync=0 only at hcnt 5,6; o_de=0 from hcnt 4; vcnt goes to 1 after hcnt 7.
REQ-030 Run a full frame (96 clks) -> o_vsync=0 only on line 4; o_de=0 on lines 3..5; o_frame_start recurs exactly 96 clks after the first.
REQ-031 Assert i_sclr at vcnt=2, hcnt=5 -> next cycle all outputs are at reset values; after release, the REQ-028 sequence repeats.
REQ-032 PIX_DIV=1 -> o_pix_en held at 1; hcnt advances every clk; frame period is 48 clks.
